// File: rtl/sr_stack.sv
// sr_stack: parametrised LIFO stack for the schoolRISCV core.
// The top of stack is held in its own register, so it is visible one cycle
// after the push, pop or replace that changes it.
// The sticky flags overflow and underflow stay set until clr_err is asserted.
// Optional feature: define SR_STACK_PEEK_EN to add the peek_idx/peek_data
// read-only port into the stack body.
module sr_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  input  logic             clr_err,
`ifdef SR_STACK_PEEK_EN
  input  logic [AW-1:0]    peek_idx,
  output logic [WIDTH-1:0] peek_data,
`endif
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] top_reg;
  logic             overflow_reg;
  logic             underflow_reg;

  logic             empty_int;
  logic             full_int;
  logic             do_push;
  logic             do_pop;
  logic             do_repl;
  logic             ovf_evt;
  logic             unf_evt;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    below_idx;
  logic [WIDTH-1:0] below_data;

  // empty and full are decoded from the registered count only.
  assign empty_int = (count_reg == '0);
  assign full_int  = (count_reg == CW'(DEPTH));

  // Command decode. A push and a pop in the same cycle replace the top entry.
  // A push while full is dropped. A pop while empty is dropped, and so is a
  // push+pop while empty.
  assign do_push = push & ~pop & ~full_int;
  assign do_pop  = pop & ~push & ~empty_int;
  assign do_repl = push & pop & ~empty_int;
  assign ovf_evt = push & ~pop & full_int;
  assign unf_evt = pop & empty_int;

  // A push writes the free slot. A replace overwrites the slot that holds the top entry.
  always_comb begin
    wr_idx = AW'(count_reg);
    if (do_repl) begin
      wr_idx = AW'(count_reg - CW'(1));
    end
  end

  // The entry below the top becomes the new top after a pop.
  // The index is held at 0 when fewer than two entries exist, so the read stays in range.
  always_comb begin
    below_idx  = '0;
    below_data = '0;
    if (count_reg >= CW'(2)) begin
      below_idx  = AW'(count_reg - CW'(2));
      below_data = mem[below_idx];
    end
  end

  // Storage array. It has no reset: slots at or above count are never read.
  always_ff @(posedge clk) begin
    if (do_push || do_repl) begin
      mem[wr_idx] <= wdata;
    end
  end

  // Pointer, top register and sticky error flags. A new error event wins over clr_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg     <= '0;
      top_reg       <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (do_push) begin
        count_reg <= count_reg + CW'(1);
        top_reg   <= wdata;
      end else if (do_pop) begin
        count_reg <= count_reg - CW'(1);
        top_reg   <= below_data;
      end else if (do_repl) begin
        top_reg   <= wdata;
      end
      overflow_reg  <= ovf_evt | (overflow_reg & ~clr_err);
      underflow_reg <= unf_evt | (underflow_reg & ~clr_err);
    end
  end

`ifdef SR_STACK_PEEK_EN
  logic          peek_hit;
  logic [AW-1:0] peek_ptr;

  // Peek reads the entry peek_idx places below the top, where 0 is the top.
  // It returns 0 when peek_idx is at or beyond count.
  always_comb begin
    peek_hit  = (CW'(peek_idx) < count_reg);
    peek_ptr  = '0;
    peek_data = '0;
    if (peek_hit) begin
      peek_ptr  = AW'(count_reg - CW'(1) - CW'(peek_idx));
      peek_data = mem[peek_ptr];
    end
  end
`endif

  assign top       = top_reg;
  assign count     = count_reg;
  assign empty     = empty_int;
  assign full      = full_int;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

endmodule

// File: tb/tb_sr_stack.sv
// tb_sr_stack: self-checking bench for sr_stack with DEPTH=4.
// Expected states go into a queue when a command is driven. They are popped
// and compared one cycle later, once the DUT has produced its output.
// Define SR_STACK_PEEK_EN to also exercise the peek port.
module tb_sr_stack;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int AW    = $clog2(DEPTH);

  typedef logic [WIDTH+CW+3:0] obs_t;

  logic             clk     = 1'b0;
  logic             rst_n   = 1'b0;
  logic             push    = 1'b0;
  logic             pop     = 1'b0;
  logic             clr_err = 1'b0;
  logic [WIDTH-1:0] wdata   = '0;
  logic [WIDTH-1:0] top;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;
`ifdef SR_STACK_PEEK_EN
  logic [AW-1:0]    peek_idx = '0;
  logic [WIDTH-1:0] peek_data;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  obs_t obs;
  obs_t exp_q[$];

  sr_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .wdata    (wdata),
    .clr_err  (clr_err),
`ifdef SR_STACK_PEEK_EN
    .peek_idx (peek_idx),
    .peek_data(peek_data),
`endif
    .top      (top),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  assign obs = {top, count, empty, full, overflow, underflow};

  // Expected observation vector. empty and full follow their definitions from count.
  function automatic obs_t mk(input logic [WIDTH-1:0] t, input int c, input logic o, input logic u);
    return {t, CW'(c), logic'(c == 0), logic'(c == DEPTH), o, u};
  endfunction

  // Drive one command for one clock edge, then return 1 time unit after that edge.
  task automatic cmd(input logic p, input logic q, input logic [WIDTH-1:0] d, input logic c);
    push = p; pop = q; wdata = d; clr_err = c;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0; clr_err = 1'b0;
  endtask

  task automatic test_reset();
    obs_t e;
    push = 1'b1; wdata = 32'hDEAD;
    #1;
    exp_q.push_back(mk(0, 0, 0, 0));
    e = exp_q.pop_front(); n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL reset_async: got %h expected %h", obs, e); end
    @(posedge clk); #1;
    exp_q.push_back(mk(0, 0, 0, 0));
    e = exp_q.pop_front(); n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL reset_push_held: got %h expected %h", obs, e); end
    @(negedge clk); push = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(mk(0, 0, 0, 0));
    e = exp_q.pop_front(); n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL reset_idle: got %h expected %h", obs, e); end
    $display("test_reset done");
  endtask

  task automatic test_fill_overflow();
    obs_t e;
    logic [WIDTH-1:0] vals [4];
    vals = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk(vals[i], i + 1, 0, 0));
      cmd(1, 0, vals[i], 0);
      e = exp_q.pop_front(); n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL fill[%0d]: got %h expected %h", i, obs, e); end
    end
    exp_q.push_back(mk(32'h44, 4, 1, 0));
    cmd(1, 0, 32'h55, 0);
    e = exp_q.pop_front(); n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL overflow: got %h expected %h", obs, e); end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk((i < 3) ? vals[2 - i] : 32'h0, 3 - i, 1, 0));
      cmd(0, 1, 32'h0, 0);
      e = exp_q.pop_front(); n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL drain[%0d]: got %h expected %h", i, obs, e); end
    end
    exp_q.push_back(mk(0, 0, 0, 0));
    cmd(0, 0, 32'h0, 1);
    e = exp_q.pop_front(); n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL clr_overflow: got %h expected %h", obs, e); end
    $display("test_fill_overflow done");
  endtask

  task automatic test_underflow();
    obs_t e;
    exp_q.push_back(mk(0, 0, 0, 1));
    cmd(0, 1, 32'h0, 0);
    e = exp_q.pop_front(); n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL underflow: got %h expected %h", obs, e); end
    exp_q.push_back(mk(0, 0, 0, 1));
    cmd(0, 1, 32'h0, 1);
    e = exp_q.pop_front(); n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL clr_vs_set: got %h expected %h", obs, e); end
    exp_q.push_back(mk(0, 0, 0, 0));
    cmd(0, 0, 32'h0, 1);
    e = exp_q.pop_front(); n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL clr_underflow: got %h expected %h", obs, e); end
    $display("test_underflow done");
  endtask

  task automatic test_replace();
    obs_t e;
    exp_q.push_back(mk(32'hA, 1, 0, 0));
    cmd(1, 0, 32'hA, 0);
    e = exp_q.pop_front(); n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL push_A: got %h expected %h", obs, e); end
    exp_q.push_back(mk(32'hB, 1, 0, 0));
    cmd(1, 1, 32'hB, 0);
    e = exp_q.pop_front(); n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL replace_B: got %h expected %h", obs, e); end
    for (int i = 2; i <= 4; i++) begin
      exp_q.push_back(mk(WIDTH'(i), i, 0, 0));
      cmd(1, 0, WIDTH'(i), 0);
      e = exp_q.pop_front(); n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL refill[%0d]: got %h expected %h", i, obs, e); end
    end
    exp_q.push_back(mk(32'h99, 4, 0, 0));
    cmd(1, 1, 32'h99, 0);
    e = exp_q.pop_front(); n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL replace_full: got %h expected %h", obs, e); end
    for (int i = 0; i < 4; i++) begin
      logic [WIDTH-1:0] t;
      case (i)
        0: t = 32'h3;
        1: t = 32'h2;
        2: t = 32'hB;
        default: t = 32'h0;
      endcase
      exp_q.push_back(mk(t, 3 - i, 0, 0));
      cmd(0, 1, 32'h0, 0);
      e = exp_q.pop_front(); n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL replace_drain[%0d]: got %h expected %h", i, obs, e); end
    end
    exp_q.push_back(mk(0, 0, 0, 1));
    cmd(1, 1, 32'hC, 0);
    e = exp_q.pop_front(); n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL replace_empty: got %h expected %h", obs, e); end
    exp_q.push_back(mk(0, 0, 0, 0));
    cmd(0, 0, 32'h0, 1);
    e = exp_q.pop_front(); n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL replace_clr: got %h expected %h", obs, e); end
    $display("test_replace done");
  endtask

  task automatic test_reset_mid();
    obs_t e;
    exp_q.push_back(mk(0, 0, 0, 1));
    cmd(0, 1, 32'h0, 0);
    e = exp_q.pop_front(); n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL mid_underflow: got %h expected %h", obs, e); end
    for (int i = 1; i <= 2; i++) begin
      exp_q.push_back(mk(WIDTH'(i), i, 0, 1));
      cmd(1, 0, WIDTH'(i), 0);
      e = exp_q.pop_front(); n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL mid_push[%0d]: got %h expected %h", i, obs, e); end
    end
    push = 1'b1; wdata = 32'h3;
    #2; rst_n = 1'b0;
    #1;
    exp_q.push_back(mk(0, 0, 0, 0));
    e = exp_q.pop_front(); n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL mid_async_reset: got %h expected %h", obs, e); end
    @(negedge clk); push = 1'b0; rst_n = 1'b1;
    exp_q.push_back(mk(32'h7, 1, 0, 0));
    cmd(1, 0, 32'h7, 0);
    e = exp_q.pop_front(); n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL mid_after_reset: got %h expected %h", obs, e); end
    $display("test_reset_mid done");
  endtask

  // Random back-to-back traffic, scored against a queue-based LIFO model.
  task automatic test_back_to_back();
    obs_t e;
    logic [WIDTH-1:0] mstk[$];
    logic mo, mu, p, q, c, ev_o, ev_u;
    logic [WIDTH-1:0] d, t;
    mstk.push_back(32'h7);
    mo = 1'b0; mu = 1'b0;
    for (int i = 0; i < 60; i++) begin
      p = ($urandom_range(0, 99) < 55);
      q = ($urandom_range(0, 99) < 45);
      c = ($urandom_range(0, 7) == 0);
      d = $urandom;
      ev_o = p && !q && (mstk.size() == DEPTH);
      ev_u = q && (mstk.size() == 0);
      if (p && !q && !ev_o) mstk.push_back(d);
      else if (!p && q && !ev_u) void'(mstk.pop_back());
      else if (p && q && !ev_u) mstk[mstk.size() - 1] = d;
      mo = ev_o | (mo & ~c);
      mu = ev_u | (mu & ~c);
      t = (mstk.size() > 0) ? mstk[mstk.size() - 1] : '0;
      exp_q.push_back(mk(t, mstk.size(), mo, mu));
      cmd(p, q, d, c);
      e = exp_q.pop_front(); n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL b2b[%0d] push=%0b pop=%0b clr=%0b: got %h expected %h", i, p, q, c, obs, e); end
    end
    $display("test_back_to_back done");
  endtask

`ifdef SR_STACK_PEEK_EN
  task automatic test_peek();
    obs_t e;
    logic [WIDTH-1:0] pe;
    @(negedge clk); rst_n = 1'b0;
    #1; rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back(mk(WIDTH'(i), i, 0, 0));
      cmd(1, 0, WIDTH'(i), 0);
      e = exp_q.pop_front(); n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL peek_push[%0d]: got %h expected %h", i, obs, e); end
    end
    for (int i = 0; i < 4; i++) begin
      peek_idx = AW'(i);
      #1;
      pe = (i < 3) ? WIDTH'(3 - i) : '0;
      n_checks++;
      if (peek_data !== pe) begin n_fail++; $display("FAIL peek[%0d]: got %h expected %h", i, peek_data, pe); end
    end
    $display("test_peek done");
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill_overflow();
    test_underflow();
    test_replace();
    test_reset_mid();
    test_back_to_back();
`ifdef SR_STACK_PEEK_EN
    test_peek();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
